// File: rtl/scan_pkg.sv
// Shared types and constants for the digit scan controller.
// SCAN_ACTIVE_LOW_EN selects a low-true onehot drive polarity.
package scan_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEL_WIDTH  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StShow
    } scan_state_t;

`ifdef SCAN_ACTIVE_LOW_EN
    localparam logic [NUM_DIGITS-1:0] ONEHOT_IDLE = 4'b1111;
`else
    localparam logic [NUM_DIGITS-1:0] ONEHOT_IDLE = 4'b0000;
`endif

    function automatic logic [NUM_DIGITS-1:0] onehot_of(input logic [SEL_WIDTH-1:0] s);
        return NUM_DIGITS'(1) << s;
    endfunction

endpackage

// File: rtl/rr_next_index.sv
// Rotate-priority search for the next enabled digit after cur_sel.
// Search order is cur_sel+1, +2, +3, then cur_sel itself (mod 4).
module rr_next_index
    import scan_pkg::*;
(
    input  logic [SEL_WIDTH-1:0]  cur_sel,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_WIDTH-1:0]  next_sel,
    output logic                  wrap,
    output logic                  any_en
);

    logic [SEL_WIDTH-1:0] cand;

    // Walk from farthest to nearest so the nearest enabled candidate wins.
    always_comb begin
        next_sel = cur_sel;
        cand     = cur_sel;
        for (int i = NUM_DIGITS; i >= 1; i--) begin
            cand = cur_sel + SEL_WIDTH'(i);
            if (digit_mask[cand]) begin
                next_sel = cand;
            end
        end
    end

    assign wrap   = (next_sel <= cur_sel);
    assign any_en = |digit_mask;

endmodule

// File: rtl/scan_select_gen.sv
// Time-multiplexed digit scan controller with blanking and mask-skip.
// Define SCAN_ACTIVE_LOW_EN to drive onehot low-true (idle 4'b1111).
module scan_select_gen
    import scan_pkg::*;
#(
    parameter int unsigned DIV_WIDTH    = 16,
    parameter int unsigned DIV          = 50000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic                  sel_valid,
    output logic [NUM_DIGITS-1:0] onehot,
    output logic                  frame_done
);

    localparam logic [DIV_WIDTH-1:0] DIV_LAST   = DIV_WIDTH'(DIV - 1);
    localparam logic [DIV_WIDTH-1:0] BLANK_LOAD =
        (BLANK_CYCLES == 0) ? '0 : DIV_WIDTH'(BLANK_CYCLES - 1);

    scan_state_t            state_q, state_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic                   sel_valid_q, sel_valid_d;
    logic [NUM_DIGITS-1:0]  onehot_q, onehot_d;
    logic                   frame_done_q, frame_done_d;
    logic [DIV_WIDTH-1:0]   presc_q, presc_d;
    logic [DIV_WIDTH-1:0]   blank_q, blank_d;

    logic [SEL_WIDTH-1:0]   cur_sel;
    logic [SEL_WIDTH-1:0]   next_sel;
    logic                   wrap;
    logic                   any_en;
    logic                   tick;
    logic                   show_d;

    // From IDLE, pretend the last index was 3 so the search starts at 0.
    assign cur_sel = (state_q == StIdle) ? SEL_WIDTH'(NUM_DIGITS - 1) : sel_q;
    assign tick    = (state_q != StIdle) && (presc_q == DIV_LAST);

    rr_next_index u_next (
        .cur_sel    (cur_sel),
        .digit_mask (digit_mask),
        .next_sel   (next_sel),
        .wrap       (wrap),
        .any_en     (any_en)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        presc_d      = presc_q;
        blank_d      = blank_q;
        frame_done_d = 1'b0;

        if (!en || !any_en) begin
            state_d = StIdle;
            presc_d = '0;
            blank_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    sel_d   = next_sel;
                    presc_d = '0;
                    blank_d = BLANK_LOAD;
                    state_d = (BLANK_CYCLES == 0) ? StShow : StBlank;
                end
                StBlank, StShow: begin
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    // A tick wins over the blank-to-show transition.
                    if (tick) begin
                        sel_d        = next_sel;
                        frame_done_d = wrap;
                        blank_d      = BLANK_LOAD;
                        state_d      = (BLANK_CYCLES == 0) ? StShow : StBlank;
                    end else if (state_q == StBlank) begin
                        if (blank_q == '0) begin
                            state_d = StShow;
                        end else begin
                            blank_d = blank_q - 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        show_d      = (state_d == StShow);
        sel_valid_d = (state_d != StIdle) && digit_mask[sel_d];
        onehot_d    = ONEHOT_IDLE ^ (show_d ? (onehot_of(sel_d) & digit_mask) : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            sel_valid_q  <= 1'b0;
            onehot_q     <= ONEHOT_IDLE;
            frame_done_q <= 1'b0;
            presc_q      <= '0;
            blank_q      <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            sel_valid_q  <= sel_valid_d;
            onehot_q     <= onehot_d;
            frame_done_q <= frame_done_d;
            presc_q      <= presc_d;
            blank_q      <= blank_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign onehot     = onehot_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_scan_select_gen.sv
// Directed bench for scan_select_gen with DIV=8, BLANK_CYCLES=2.
// Build with SCAN_ACTIVE_LOW_EN to check the inverted onehot polarity.
module tb_scan_select_gen;

`ifdef SCAN_ACTIVE_LOW_EN
    localparam logic [3:0] INV = 4'b1111;
`else
    localparam logic [3:0] INV = 4'b0000;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] digit_mask;
    logic [1:0] sel;
    logic       sel_valid;
    logic [3:0] onehot;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    scan_select_gen #(
        .DIV_WIDTH    (16),
        .DIV          (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digit_mask (digit_mask),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .onehot     (onehot),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the first n cycles of a scan step showing digit s.
    task automatic check_step(input logic [1:0] s, input logic [3:0] m, input logic fd,
                              input int n);
        logic [3:0] oh;
        logic       fd_exp;
        for (int c = 0; c < n; c++) begin
            step();
            oh     = (c < 2) ? 4'b0000 : ((4'b0001 << s) & m);
            fd_exp = (c == 0) ? fd : 1'b0;
            checks++;
            if ({sel, sel_valid, onehot, frame_done} !== {s, 1'b1, oh ^ INV, fd_exp}) begin
                errors++;
                $display("FAIL step sel%0d cycle%0d: got sel=%0d valid=%b onehot=%b fd=%b, want sel=%0d valid=1 onehot=%b fd=%b",
                         s, c, sel, sel_valid, onehot, frame_done, s, oh ^ INV, fd_exp);
            end
        end
    endtask

    task automatic go_idle(input logic [1:0] s_exp);
        en = 1'b0;
        step();
        checks++;
        if ({sel, sel_valid, onehot, frame_done} !== {s_exp, 1'b0, INV, 1'b0}) begin
            errors++;
            $display("FAIL idle: got sel=%0d valid=%b onehot=%b fd=%b, want sel=%0d valid=0 onehot=%b fd=0",
                     sel, sel_valid, onehot, frame_done, s_exp, INV);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        en         = 1'b0;
        digit_mask = 4'b0000;
        step();
        step();
        checks++;
        if ({sel, sel_valid, onehot, frame_done} !== {2'd0, 1'b0, INV, 1'b0}) begin
            errors++;
            $display("FAIL reset: got sel=%0d valid=%b onehot=%b fd=%b, want sel=0 valid=0 onehot=%b fd=0",
                     sel, sel_valid, onehot, frame_done, INV);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_mask();
        digit_mask = 4'b1111;
        en         = 1'b1;
        check_step(2'd0, 4'b1111, 1'b0, 8);
        check_step(2'd1, 4'b1111, 1'b0, 8);
        check_step(2'd2, 4'b1111, 1'b0, 8);
        check_step(2'd3, 4'b1111, 1'b0, 8);
        check_step(2'd0, 4'b1111, 1'b1, 8);
    endtask

    task automatic test_sparse_mask();
        go_idle(2'd0);
        digit_mask = 4'b1010;
        en         = 1'b1;
        check_step(2'd1, 4'b1010, 1'b0, 8);
        check_step(2'd3, 4'b1010, 1'b0, 8);
        check_step(2'd1, 4'b1010, 1'b1, 8);
        check_step(2'd3, 4'b1010, 1'b0, 8);
        check_step(2'd1, 4'b1010, 1'b1, 8);
    endtask

    task automatic test_single_digit();
        go_idle(2'd1);
        digit_mask = 4'b0100;
        en         = 1'b1;
        check_step(2'd2, 4'b0100, 1'b0, 8);
        check_step(2'd2, 4'b0100, 1'b1, 8);
        check_step(2'd2, 4'b0100, 1'b1, 8);
    endtask

    task automatic test_mask_change();
        go_idle(2'd2);
        digit_mask = 4'b1111;
        en         = 1'b1;
        check_step(2'd0, 4'b1111, 1'b0, 8);
        check_step(2'd1, 4'b1111, 1'b0, 4);
        digit_mask = 4'b1101;
        for (int c = 4; c < 8; c++) begin
            step();
            checks++;
            if ({sel, sel_valid, onehot, frame_done} !== {2'd1, 1'b0, INV, 1'b0}) begin
                errors++;
                $display("FAIL masked_sel cycle%0d: got sel=%0d valid=%b onehot=%b fd=%b, want sel=1 valid=0 onehot=%b fd=0",
                         c, sel, sel_valid, onehot, frame_done, INV);
            end
        end
        check_step(2'd2, 4'b1101, 1'b0, 8);
        digit_mask = 4'b0000;
        step();
        checks++;
        if ({sel_valid, onehot, frame_done} !== {1'b0, INV, 1'b0}) begin
            errors++;
            $display("FAIL mask_zero: got valid=%b onehot=%b fd=%b, want valid=0 onehot=%b fd=0",
                     sel_valid, onehot, frame_done, INV);
        end
    endtask

    task automatic test_async_reset();
        digit_mask = 4'b1111;
        check_step(2'd0, 4'b1111, 1'b0, 8);
        check_step(2'd1, 4'b1111, 1'b0, 8);
        check_step(2'd2, 4'b1111, 1'b0, 1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({sel, sel_valid, onehot, frame_done} !== {2'd0, 1'b0, INV, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got sel=%0d valid=%b onehot=%b fd=%b, want sel=0 valid=0 onehot=%b fd=0",
                     sel, sel_valid, onehot, frame_done, INV);
        end
        step();
        rst = 1'b0;
        check_step(2'd0, 4'b1111, 1'b0, 8);
        check_step(2'd1, 4'b1111, 1'b0, 2);
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_single_digit();
        test_mask_change();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
